// File: rtl/submatrix_load_scheduler_pkg.sv
// Shared types and defaults for the submatrix load scheduler.
// State encoding is fixed so the state register maps directly onto debug probes.
package submatrix_load_scheduler_pkg;

   localparam int GROUP_W_DEF      = 16;
   localparam int NUM_GROUPS_DEF   = 256;
   localparam int IDX_W_DEF        = 8;
   localparam int FILL_TIMEOUT_DEF = 1024;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FILL  = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/submatrix_load_scheduler_watchdog.sv
// Fill watchdog: clearable up-counter that flags when it reaches LIMIT-1.
// It holds at the terminal count until cleared.
module fill_watchdog #(
   parameter int LIMIT = 1024
) (
   input  logic clock,
   input  logic resetN,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expired = (cnt_q == CW'(LIMIT - 1));

   // next count: clear wins, then count up until terminal
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // counter register
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/submatrix_load_scheduler.sv
// Runs one image pass of the submatrix generator and hands each
// captured group downstream over valid/ready.
module submatrix_load_scheduler
   import submatrix_load_scheduler_pkg::*;
#(
   parameter int GROUP_W      = GROUP_W_DEF,
   parameter int NUM_GROUPS   = NUM_GROUPS_DEF,
   parameter int IDX_W        = IDX_W_DEF,
   parameter int FILL_TIMEOUT = FILL_TIMEOUT_DEF
) (
   input  logic               clock,
   input  logic               resetN,
   input  logic               start,
   input  logic               abort,
   output logic               gen_clear_n,
   output logic               gen_ready,
   input  logic               gen_loaded,
   input  logic [GROUP_W-1:0] gen_elements,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [GROUP_W-1:0] out_data,
   output logic [IDX_W-1:0]   out_index,
   output logic               busy,
   output logic               done,
   output logic               overrun,
   output logic               timeout
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_GROUPS - 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   count_q, count_d;
   logic [IDX_W-1:0]   index_q, index_d;
   logic [GROUP_W-1:0] data_q, data_d;
   logic               overrun_q, overrun_d;
   logic               timeout_q, timeout_d;
   logic               wd_clear, wd_en, wd_expired;

   assign wd_en    = (state_q == S_FILL);
   assign wd_clear = (state_q != S_FILL) || gen_loaded;

   fill_watchdog #(
      .LIMIT (FILL_TIMEOUT)
   ) u_watchdog (
      .clock   (clock),
      .resetN  (resetN),
      .clear   (wd_clear),
      .enable  (wd_en),
      .expired (wd_expired)
   );

   // next state, capture and sticky flags; abort overrides the pass
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      index_d   = index_q;
      data_d    = data_q;
      overrun_d = overrun_q;
      timeout_d = timeout_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d   = S_CLEAR;
               count_d   = '0;
               overrun_d = 1'b0;
               timeout_d = 1'b0;
            end
         end
         S_CLEAR: state_d = S_FILL;
         S_FILL: begin
            if (gen_loaded) begin
               data_d  = gen_elements;
               index_d = count_q;
               state_d = S_HOLD;
            end else if (wd_expired) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               if (index_q == LAST) begin
                  state_d = S_DONE;
               end else begin
                  count_d = count_q + IDX_W'(1);
                  state_d = S_FILL;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort && state_q != S_IDLE) begin
         state_d   = S_IDLE;
         count_d   = count_q;
         index_d   = index_q;
         data_d    = data_q;
         timeout_d = timeout_q;
      end
      if (gen_loaded && state_q != S_FILL) begin
         overrun_d = 1'b1;
      end
   end

   // Moore output decode from the state register
   always_comb begin
      gen_clear_n = 1'b1;
      gen_ready   = 1'b0;
      out_valid   = 1'b0;
      done        = 1'b0;
      busy        = (state_q != S_IDLE);
      unique case (state_q)
         S_CLEAR: gen_clear_n = 1'b0;
         S_FILL:  gen_ready   = 1'b1;
         S_HOLD:  out_valid   = 1'b1;
         S_DONE:  done        = 1'b1;
         default: ;
      endcase
   end

   assign out_data  = data_q;
   assign out_index = index_q;
   assign overrun   = overrun_q;
   assign timeout   = timeout_q;

   // state, capture and flag registers
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         index_q   <= '0;
         data_q    <= '0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         index_q   <= index_d;
         data_q    <= data_d;
         overrun_q <= overrun_d;
         timeout_q <= timeout_d;
      end
   end

endmodule

// File: tb/tb_submatrix_load_scheduler.sv
// Directed bench for submatrix_load_scheduler: 4-group passes, stall,
// overrun, abort, async reset, and a short-timeout instance.
module tb_submatrix_load_scheduler;

   logic        clock = 1'b0;
   logic        resetN = 1'b0;
   logic        start = 1'b0, abort = 1'b0;
   logic        gen_loaded = 1'b0;
   logic [15:0] gen_elements = '0;
   logic        out_ready = 1'b1;
   logic        gen_clear_n, gen_ready, out_valid, busy, done;
   logic        overrun, timeout;
   logic [15:0] out_data;
   logic [7:0]  out_index;

   logic        start_to = 1'b0, abort_to = 1'b0;
   logic        gen_loaded_to = 1'b0, out_ready_to = 1'b1;
   logic [15:0] gen_elements_to = '0;
   logic        gen_clear_n_to, gen_ready_to, out_valid_to;
   logic        busy_to, done_to, overrun_to, timeout_to;
   logic [15:0] out_data_to;
   logic [7:0]  out_index_to;

   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;
   int done_to_cnt = 0;
   int d0;

   always #5 clock = ~clock;

   submatrix_load_scheduler #(
      .GROUP_W(16), .NUM_GROUPS(4), .IDX_W(8), .FILL_TIMEOUT(1024)
   ) dut (
      .clock(clock), .resetN(resetN), .start(start), .abort(abort),
      .gen_clear_n(gen_clear_n), .gen_ready(gen_ready),
      .gen_loaded(gen_loaded), .gen_elements(gen_elements),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_index(out_index),
      .busy(busy), .done(done), .overrun(overrun), .timeout(timeout)
   );

   submatrix_load_scheduler #(
      .GROUP_W(16), .NUM_GROUPS(4), .IDX_W(8), .FILL_TIMEOUT(8)
   ) dut_to (
      .clock(clock), .resetN(resetN), .start(start_to), .abort(abort_to),
      .gen_clear_n(gen_clear_n_to), .gen_ready(gen_ready_to),
      .gen_loaded(gen_loaded_to), .gen_elements(gen_elements_to),
      .out_valid(out_valid_to), .out_ready(out_ready_to),
      .out_data(out_data_to), .out_index(out_index_to),
      .busy(busy_to), .done(done_to), .overrun(overrun_to),
      .timeout(timeout_to)
   );

   always @(negedge clock) begin
      if (done) done_cnt++;
      if (done_to) done_to_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start_pass();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("clr_lo", gen_clear_n, 1'b0);
      chk("clr_busy", busy, 1'b1);
      tick();
      chk("clr_hi", gen_clear_n, 1'b1);
   endtask

   task automatic gen_group(input logic [15:0] d, input int idx,
                            input int stall, input bit inj);
      int n;
      n = 0;
      while (!gen_ready && n < 64) begin
         tick();
         n++;
      end
      chk("gen_rdy", gen_ready, 1'b1);
      repeat (15) tick();
      gen_elements = d;
      gen_loaded = 1'b1;
      if (stall > 0) out_ready = 1'b0;
      tick();
      gen_loaded = 1'b0;
      gen_elements = '0;
      chk("vld", out_valid, 1'b1);
      chk("idx", out_index, idx);
      chk("data", out_data, d);
      chk("stalled", gen_ready, 1'b0);
      for (int i = 0; i < stall; i++) begin
         if (inj && i == 3) begin
            gen_loaded = 1'b1;
            gen_elements = 16'hdead;
         end
         tick();
         gen_loaded = 1'b0;
         gen_elements = '0;
         chk("hold_vld", out_valid, 1'b1);
         chk("hold_idx", out_index, idx);
         chk("hold_data", out_data, d);
         chk("hold_rdy", gen_ready, 1'b0);
      end
      if (inj) chk("ovr_set", overrun, 1'b1);
      out_ready = 1'b1;
      tick();
      chk("vld_drop", out_valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang want finish");
      $fatal(1);
   end

   initial begin
      #22 resetN = 1'b1;
      tick();
      chk("rst_clrn", gen_clear_n, 1'b1);
      chk("rst_rdy", gen_ready, 1'b0);
      chk("rst_vld", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_flags", {overrun, timeout}, 2'b00);
      chk("rst_data", out_data, 16'h0);
      chk("rst_idx", out_index, 8'h0);

      // pass A: consumer always ready
      d0 = done_cnt;
      start_pass();
      for (int g = 0; g < 4; g++) gen_group(16'ha500 + 16'(g), g, 0, 0);
      chk("a_done", done, 1'b1);
      chk("a_busy_d", busy, 1'b1);
      tick();
      chk("a_done_lo", done, 1'b0);
      chk("a_busy_lo", busy, 1'b0);
      chk("a_done_cnt", done_cnt - d0, 1);
      chk("a_ovr", overrun, 1'b0);

      // pass B: stall group 1 for 10 cycles with an overrun strobe
      d0 = done_cnt;
      start_pass();
      for (int g = 0; g < 4; g++)
         gen_group(16'h3c00 + 16'(g * 3), g, (g == 1) ? 10 : 0, g == 1);
      chk("b_done", done, 1'b1);
      chk("b_ovr_done", overrun, 1'b1);
      tick();
      chk("b_done_cnt", done_cnt - d0, 1);
      chk("b_ovr_keep", overrun, 1'b1);

      // pass C: start clears overrun; abort in HOLD of group 2
      d0 = done_cnt;
      start_pass();
      chk("c_ovr_clr", overrun, 1'b0);
      gen_group(16'h0f01, 0, 0, 0);
      gen_group(16'h0f02, 1, 0, 0);
      out_ready = 1'b0;
      repeat (15) tick();
      gen_elements = 16'h0f03;
      gen_loaded = 1'b1;
      tick();
      gen_loaded = 1'b0;
      chk("c_vld", out_valid, 1'b1);
      chk("c_idx", out_index, 8'd2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      out_ready = 1'b1;
      chk("c_ab_vld", out_valid, 1'b0);
      chk("c_ab_busy", busy, 1'b0);
      chk("c_ab_rdy", gen_ready, 1'b0);
      tick();
      chk("c_ab_done", done_cnt - d0, 0);

      // pass D: restart from index 0, then async reset mid-FILL
      start_pass();
      gen_group(16'h7777, 0, 0, 0);
      repeat (3) tick();
      chk("d_fill", gen_ready, 1'b1);
      #2 resetN = 1'b0;
      #1;
      chk("ar_rdy", gen_ready, 1'b0);
      chk("ar_busy", busy, 1'b0);
      chk("ar_clrn", gen_clear_n, 1'b1);
      chk("ar_data", out_data, 16'h0);
      chk("ar_idx", out_index, 8'h0);
      #2 resetN = 1'b1;
      tick();
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("sa_busy", busy, 1'b0);
      chk("sa_clrn", gen_clear_n, 1'b1);

      // short-timeout instance, generator silent
      d0 = done_to_cnt;
      start_to = 1'b1;
      tick();
      start_to = 1'b0;
      chk("to_clr", gen_clear_n_to, 1'b0);
      tick();
      chk("to_fill", gen_ready_to, 1'b1);
      repeat (7) tick();
      chk("to_early", {timeout_to, busy_to}, 2'b01);
      tick();
      chk("to_set", timeout_to, 1'b1);
      chk("to_busy", busy_to, 1'b0);
      chk("to_rdy", gen_ready_to, 1'b0);
      tick();
      chk("to_done", done_to_cnt - d0, 0);
      chk("to_keep", timeout_to, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/submatrix_load_scheduler.md
Name: submatrix_load_scheduler

Overview:
- Sequences one full-image pass of the submatrix generator: restarts its address counter, enables it, captures each 16-element group it reports as loaded, and hands each group downstream over a valid/ready handshake.
- Stalls the generator while downstream is busy, counts groups, signals pass completion, and flags protocol faults (overrun, fill timeout).
- Sits between the top-level control FSM (start/abort) and the submatrix consumer (matcher/accumulator).

Parameters:
GROUP_W, 16, width of one grouped submatrix (elements per group)
NUM_GROUPS, 256, groups per image pass
IDX_W, 8, width of group index (>= clog2(NUM_GROUPS))
FILL_TIMEOUT, 1024, max cycles in FILL without gen_loaded before fault

Ports:
clock  in  1  system clock, rising edge
resetN  in  1  asynchronous active-low reset
start  in  1  begin pass; sampled only in IDLE
abort  in  1  cancel pass from any state
gen_clear_n  out  1  active-low clear to generator resetN, low for exactly one cycle per pass
gen_ready  out  1  drives generator readyToBeLoaded
gen_loaded  in  1  generator "group complete" strobe
gen_elements  in  GROUP_W  generator grouped elements, valid with gen_loaded
out_valid  out  1  captured group available
out_ready  in  1  consumer accepts group
out_data  out  GROUP_W  captured group
out_index  out  IDX_W  index of captured group, 0..NUM_GROUPS-1
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when pass completes normally
overrun  out  1  sticky: gen_loaded seen outside FILL; cleared on accepted start
timeout  out  1  sticky: FILL_TIMEOUT expired; cleared on accepted start

Behaviour:
- Reset (resetN low, async): state IDLE. All outputs 0 except gen_clear_n=1. Group count 0, watchdog 0, out_data 0.
- Single clock domain. All outputs registered or Moore-decoded from registered state; no combinational in-to-out paths.
- States: IDLE, CLEAR, FILL, HOLD, DONE.
- IDLE: gen_ready=0. start=1 and abort=0 -> CLEAR. On this transition: clear overrun and timeout, group count=0.
- CLEAR: gen_clear_n=0 for this one cycle -> FILL.
- FILL:
  - gen_ready=1; watchdog increments each cycle.
  - gen_loaded=1: latch gen_elements into out_data and group count into out_index, watchdog=0 -> HOLD.
  - Watchdog reaches FILL_TIMEOUT-1 with no gen_loaded: set timeout -> IDLE, no done.
- HOLD:
  - out_valid=1, gen_ready=0 (generator stalled); out_data and out_index stable.
  - out_ready=1 (handshake): out_valid drops next cycle.
    - If out_index==NUM_GROUPS-1 -> DONE.
    - Else group count+1 -> FILL.
  - gen_loaded=1 in HOLD: set overrun; strobe ignored; data not overwritten.
- DONE: done=1 for one cycle -> IDLE.
- abort=1 in any non-IDLE state: next cycle IDLE; out_valid=0, gen_ready=0, no done; sticky flags retained.
- start outside IDLE: ignored. start and abort together in IDLE: abort wins, stay IDLE.
- gen_loaded in IDLE, CLEAR or DONE: set overrun, otherwise ignored.
- Index arithmetic is IDX_W-bit unsigned; the group count never wraps within a pass (terminates at NUM_GROUPS-1).
- Latency:
  - start to gen_clear_n low: 1 cycle.
  - gen_loaded to out_valid: 1 cycle.
  - Final handshake to done: 1 cycle.
- resetN asserted mid-pass: immediate return to reset values; gen_clear_n stays 1 (generator shares resetN).

Decomposition:
- Shared header submatrix_defs.vh holds:
  - state encoding localparams (IDLE=0, CLEAR=1, FILL=2, HOLD=3, DONE=4, 3 bits);
  - default GROUP_W=16;
  - default NUM_GROUPS=256.
- One sub-module: fill_watchdog, a clearable up-counter with terminal-count flag. Ports: clock, resetN, clear, enable, expired; parameter LIMIT.
- The main FSM, capture register and group counter stay in the top module.

Test Plan:
- NUM_GROUPS=4, consumer always ready, generator model strobes gen_loaded 16 cycles after gen_ready rises -> gen_clear_n low one cycle; out_index sequence 0,1,2,3; done pulses once; busy falls with done.
- Consumer holds out_ready=0 for 10 cycles on group 1 -> gen_ready=0 and out_data/out_index (=1) stable for all 10 cycles; no loss; pass completes with 4 groups.
- gen_loaded pulsed while in HOLD -> overrun=1 and stays 1 through done; out_data unchanged; next accepted start clears it.
- FILL_TIMEOUT=8, generator never strobes -> timeout=1 after 8 FILL cycles; state IDLE; done never asserted; busy=0.
- abort asserted in HOLD of group 2 -> next cycle out_valid=0, busy=0, no done; new start restarts at out_index 0 with a fresh gen_clear_n pulse.
- resetN pulsed low asynchronously mid-FILL (between clock edges) -> outputs return to reset values immediately; start and abort together in IDLE -> remains IDLE.
